// File: rtl/mem_responder.sv
// Single-port word memory behind a request/ready handshake with a fixed
// number of wait states per access and an out-of-range error flag.
//
// Handshake: the requester raises req with we/addr/wdata/be; the request is
// accepted on the rising edge where the FSM is in IDLE and req=1, and all
// fields are captured there. Exactly WAIT_CYCLES+1 clocks later ready pulses
// for one cycle with rdata/err valid; rdata and err are 0 at all other times.
// busy covers the accepting IDLE cycle through the ready cycle, so a requester
// holding req across back-to-back accesses sees busy stay high.
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0]  DEPTH_L = 9'(DEPTH);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Fields used by the access on the RESP-entry edge. With zero wait states
  // that edge is also the accepting edge, so the live inputs are the values
  // being sampled; otherwise only the captured copies are used.
  logic        acc_we;
  logic [7:0]  acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic [AW-1:0] acc_idx;
  logic        mem_wr;

  logic [31:0] mem [DEPTH];

  // Next-state, capture and access decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = 32'h0;
    err_d     = 1'b0;
    mem_wr    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          cnt_d   = WAIT_LD;
          if (WAIT_CYCLES == 0) begin
            state_d   = RESP;
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_be    = be;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    acc_idx = acc_addr[AW-1:0];

    // RESP always exits to IDLE, so state_d==RESP marks the entry edge only
    if (state_d == RESP) begin
      if ({1'b0, acc_addr} >= DEPTH_L) begin
        err_d = 1'b1;
      end else if (acc_we) begin
        mem_wr = 1'b1;
      end else begin
        rdata_d = mem[acc_idx];
      end
    end
  end

  // Control and response registers; reset abandons any transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'h0;
      we_q    <= 1'b0;
      addr_q  <= 8'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array: byte-masked write on the RESP-entry edge, not reset
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign ready     = (state_q == RESP);
  assign busy      = (state_q != IDLE) || req;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance a uses two wait states, instance b uses
// zero wait states with continuously held req.
module tb_mem_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_a, we_a, req_b, we_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b, rdata_a, rdata_b;
  logic [3:0]  be_a, be_b;
  logic        ready_a, busy_a, err_a, ready_b, busy_b, err_b;
  logic [1:0]  dbg_a, dbg_b;

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .be(be_a), .rdata(rdata_a), .ready(ready_a),
    .busy(busy_a), .err(err_a), .dbg_state(dbg_a)
  );

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .be(be_b), .rdata(rdata_b), .ready(ready_b),
    .busy(busy_b), .err(err_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];            // {err, rdata}
  logic [31:0] model_a [64];
  logic [31:0] model_b [64];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [32:0] step_a(logic w, logic [7:0] a, logic [31:0] d, logic [3:0] b);
    logic [32:0] e;
    if (a >= 8'd64) e = {1'b1, 32'h0};
    else if (w) begin
      for (int i = 0; i < 4; i++) if (b[i]) model_a[a[5:0]][8*i +: 8] = d[8*i +: 8];
      e = 33'h0;
    end else e = {1'b0, model_a[a[5:0]]};
    return e;
  endfunction

  function automatic logic [32:0] step_b(logic w, logic [7:0] a, logic [31:0] d, logic [3:0] b);
    logic [32:0] e;
    if (a >= 8'd64) e = {1'b1, 32'h0};
    else if (w) begin
      for (int i = 0; i < 4; i++) if (b[i]) model_b[a[5:0]][8*i +: 8] = d[8*i +: 8];
      e = 33'h0;
    end else e = {1'b0, model_b[a[5:0]]};
    return e;
  endfunction

  task automatic compare_resp(input string tag, input logic [32:0] got);
    logic [32:0] e;
    if (exp_q.size() == 0) chk({tag, "_noexp"}, 0, 1);
    else begin
      e = exp_q.pop_front();
      chk({tag, "_err"}, got[32], e[32]);
      chk({tag, "_rdata"}, got[31:0], e[31:0]);
    end
  endtask

  // ---------------- drivers ----------------
  // One access on instance a, called at a falling edge. Inputs are scrambled
  // right after acceptance to show they are ignored.
  task automatic access_a(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    int lat;
    bit seen;
    req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d; be_a = b;
    exp_q.push_back(step_a(w, a, d, b));
    @(posedge clk); #1;
    req_a = 1'b0; we_a = 1'($urandom); addr_a = 8'($urandom);
    wdata_a = $urandom; be_a = 4'($urandom);
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ready_a) seen = 1;
      else chk("a_busy_wait", busy_a, 1);
    end
    chk("a_latency", lat, 3);
    if (seen) begin
      chk("a_busy_ready", busy_a, 1);
      compare_resp("a", {err_a, rdata_a});
    end
    @(negedge clk);
    chk("a_ready_low", ready_a, 0);
    chk("a_idle_rdata", rdata_a, 0);
    chk("a_idle_err", err_a, 0);
    chk("a_idle_busy", busy_a, 0);
  endtask

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  b;
  } txn_t;
  txn_t blist[12];

  // ---------------- stimulus ----------------
  initial begin
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0; be_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0; be_b = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", ready_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_state", dbg_a, 0);
    chk("rst_b_ready", ready_b, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // fill every word so the model is fully known (first edge after reset)
    for (int i = 0; i < 64; i++) access_a(1'b1, 8'(i), $urandom, 4'hF);

    // read after write
    access_a(1'b1, 8'd5, 32'hDEADBEEF, 4'hF);
    access_a(1'b0, 8'd5, 32'h0, 4'h0);
    // byte enables
    access_a(1'b1, 8'd3, 32'h11223344, 4'hF);
    access_a(1'b1, 8'd3, 32'hAABBCCDD, 4'b0101);
    access_a(1'b0, 8'd3, 32'h0, 4'h0);
    // be=0 leaves word unchanged
    access_a(1'b1, 8'd4, 32'h55555555, 4'h0);
    access_a(1'b0, 8'd4, 32'h0, 4'h0);
    // out of range
    access_a(1'b0, 8'd64, 32'h0, 4'h0);
    access_a(1'b1, 8'd200, 32'hCAFEF00D, 4'hF);
    access_a(1'b0, 8'd255, 32'h0, 4'h0);
    access_a(1'b0, 8'd63, 32'h0, 4'h0);
    // random mix
    for (int i = 0; i < 30; i++)
      access_a(1'($urandom), 8'($urandom_range(0, 70)), $urandom, 4'($urandom));
    // sweep: nothing disturbed by the out-of-range write
    for (int i = 0; i < 64; i++) access_a(1'b0, 8'(i), 32'h0, 4'h0);

    // reset during WAIT of a write to addr 7 (currently 0)
    access_a(1'b1, 8'd7, 32'h0, 4'hF);
    req_a = 1'b1; we_a = 1'b1; addr_a = 8'd7; wdata_a = 32'hFFFFFFFF; be_a = 4'hF;
    @(posedge clk); #1 req_a = 1'b0;
    @(negedge clk);
    chk("mid_busy_before", busy_a, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy_rst", busy_a, 0);
    chk("mid_ready_rst", ready_a, 0);
    chk("mid_err_rst", err_a, 0);
    chk("mid_state_rst", dbg_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_no_ready", ready_a, 0);
    end
    access_a(1'b0, 8'd7, 32'h0, 4'h0);

    // reset during the ready cycle of an out-of-range read
    req_a = 1'b1; we_a = 1'b0; addr_a = 8'd64;
    @(posedge clk); #1 req_a = 1'b0;
    begin
      int n;
      n = 0;
      while (!ready_a && n < 20) begin @(negedge clk); n++; end
      chk("resp_rst_seen", ready_a, 1);
    end
    chk("resp_err_before", err_a, 1);
    rst_n = 1'b0;
    #1;
    chk("resp_ready_rst", ready_a, 0);
    chk("resp_err_rst", err_a, 0);
    chk("resp_rdata_rst", rdata_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // zero wait states, req held high across all transactions
    blist[0]  = '{1'b1, 8'd10, 32'hA0000001, 4'hF};
    blist[1]  = '{1'b1, 8'd11, 32'hA0000002, 4'hF};
    blist[2]  = '{1'b1, 8'd12, 32'hA0000003, 4'hF};
    blist[3]  = '{1'b1, 8'd13, 32'hA0000004, 4'hF};
    blist[4]  = '{1'b0, 8'd10, 32'h0, 4'h0};
    blist[5]  = '{1'b0, 8'd11, 32'h0, 4'h0};
    blist[6]  = '{1'b0, 8'd100, 32'h0, 4'h0};
    blist[7]  = '{1'b1, 8'd11, 32'h12345678, 4'b0011};
    blist[8]  = '{1'b0, 8'd11, 32'h0, 4'h0};
    blist[9]  = '{1'b0, 8'd12, 32'h0, 4'h0};
    blist[10] = '{1'b1, 8'd13, 32'hFFFFFFFF, 4'b1000};
    blist[11] = '{1'b0, 8'd13, 32'h0, 4'h0};
    for (int i = 0; i < 12; i++) begin
      req_b = 1'b1; we_b = blist[i].w; addr_b = blist[i].a;
      wdata_b = blist[i].d; be_b = blist[i].b;
      exp_q.push_back(step_b(blist[i].w, blist[i].a, blist[i].d, blist[i].b));
      #1 chk("b_busy_idle", busy_b, 1);
      @(posedge clk);
      @(negedge clk);
      chk("b_ready", ready_b, 1);
      chk("b_busy_resp", busy_b, 1);
      if (ready_b) compare_resp("b", {err_b, rdata_b});
      @(posedge clk);
      @(negedge clk);
      chk("b_gap_ready", ready_b, 0);
      chk("b_gap_rdata", rdata_b, 0);
      chk("b_gap_err", err_b, 0);
    end
    req_b = 1'b0;
    #1 chk("b_busy_end", busy_b, 0);

    chk("q_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted before each access (legal range 0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req  input  1  access request from the controller (MEM_READ/MEM_WRITE phase).
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr  input  8  word address.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port be  input  4  byte enables for writes; be[i] gates wdata[8i+7:8i].
REQ-010 SHALL have port rdata  output  32  read data; valid only while ready=1.
REQ-011 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  high from request acceptance until the ready cycle, inclusive.
REQ-013 SHALL have port err  output  1  out-of-range flag; valid only while ready=1.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT, and RESP.
REQ-015 IDLE: when req=1, SHALL latch we, addr, wdata, and be, and load the wait counter with WAIT_CYCLES.
REQ-016 IDLE: on acceptance, SHALL go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-017 IDLE with req=0 SHALL stay in IDLE.
REQ-018 WAIT SHALL decrement the counter each cycle and go to RESP on the cycle the counter reaches 1.
REQ-019 The memory access SHALL occur on the clock edge that enters RESP, using only the latched values.
REQ-020 RESP SHALL last exactly one cycle with ready=1, then return to IDLE unconditionally.
REQ-021 Latency SHALL be exactly WAIT_CYCLES+1 clocks from the edge sampling req to the cycle in which ready=1.
REQ-022 req, we, addr, wdata, and be SHALL be ignored in WAIT and RESP; input changes after acceptance SHALL not affect the transaction.
REQ-023 req still high in the first IDLE cycle after RESP SHALL start a new transaction; the requester SHALL drop req in the ready cycle for single accesses.
REQ-024 Read: rdata SHALL equal mem[addr] in the ready cycle.
REQ-025 Write: SHALL update only the enabled bytes of mem[addr] and drive rdata=0 in the ready cycle.
REQ-026 Write with be=4'b0000 SHALL complete normally and leave memory unchanged.
REQ-027 addr >= DEPTH: SHALL perform no memory access and assert err=1, rdata=0 in the ready cycle.
REQ-028 addr < DEPTH: err SHALL be 0 in the ready cycle.
REQ-029 Outside the ready cycle, rdata SHALL be 0 and err SHALL be 0.
REQ-030 A read SHALL return data from any write whose ready cycle has already occurred (no stale data).

Reset
REQ-031 rst_n=0 SHALL force state IDLE, counter 0, ready=0, busy=0, err=0, and rdata=0 immediately, without waiting for clk.
REQ-032 Reset mid-transaction SHALL abandon the transaction; a write not yet at its RESP-entry edge SHALL not modify memory.
REQ-033 Memory contents SHALL be unaffected by reset.
REQ-034 After rst_n deasserts, the first rising edge SHALL sample req normally.

Verification
REQ-035 Read after write (WAIT_CYCLES=2): write addr=5, wdata=32'hDEADBEEF, be=4'hF, then read addr=5 -> each ready exactly 3 cycles after its req edge; read rdata=32'hDEADBEEF; err=0.
REQ-036 Byte enables: mem[3]=32'h11223344, write wdata=32'hAABBCCDD with be=4'b0101, then read addr=3 -> rdata=32'h11BB33DD.
REQ-037 Out of range: read addr=8'd64 with DEPTH=64 -> ready with err=1, rdata=0; a write to addr=200 leaves all words unchanged.
REQ-038 Zero wait states (WAIT_CYCLES=0): back-to-back requests with req held continuously -> ready every 2nd cycle; busy never drops; each read returns correct data.
REQ-039 Reset mid-operation: assert rst_n=0 while in WAIT of a write to addr=7 (old value 32'h0) -> ready, busy, and err fall immediately; no ready pulse follows; a later read of addr=7 returns 32'h0.
REQ-040 Input isolation: change addr and wdata during WAIT -> the access uses the values sampled at acceptance.
